// File: rtl/rc5_dec_16bit.sv
// Single-round RC5 decryptor for 8-bit words and 4 subkeys, running one step per clock.
// Define RC5_DEC_SELFCHECK_EN to add a re-encryption self-check that drives dec_err.
module rc5_dec_16bit #(
  parameter logic [7:0] S0 = 8'h20,
  parameter logic [7:0] S1 = 8'h10,
  parameter logic [7:0] S2 = 8'hFF,
  parameter logic [7:0] S3 = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dec_start,
  input  logic [15:0] c,
  output logic [15:0] p,
  output logic        busy,
  output logic        dec_done,
  output logic        dec_err
);

`ifdef RC5_DEC_SELFCHECK_EN
  typedef enum logic [2:0] {
    IDLE, RND_B, RND_A, POST, DONE, CHK_PRE, CHK_A, CHK_B
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RND_B, RND_A, POST, DONE
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] p_q, p_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef RC5_DEC_SELFCHECK_EN
  logic [15:0] ct_q, ct_d;
  logic [7:0]  ea_q, ea_d, eb_q, eb_d;
  logic        err_q, err_d;
`endif

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} >> n;
    return t[7:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RC5_DEC_SELFCHECK_EN
      ct_q    <= '0;
      ea_q    <= '0;
      eb_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RC5_DEC_SELFCHECK_EN
      ct_q    <= ct_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef RC5_DEC_SELFCHECK_EN
    ct_d    = ct_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (dec_start) begin
          a_d     = c[15:8];
          b_d     = c[7:0];
`ifdef RC5_DEC_SELFCHECK_EN
          ct_d    = c;
`endif
          busy_d  = 1'b1;
          state_d = RND_B;
        end
      end
      RND_B: begin
        b_d     = rotr8(b_q - S3, a_q[2:0]) ^ a_q;
        state_d = RND_A;
      end
      RND_A: begin
        // b_q already holds the B value updated in RND_B
        a_d     = rotr8(a_q - S2, b_q[2:0]) ^ b_q;
        state_d = POST;
      end
      POST: begin
        a_d     = a_q - S0;
        b_d     = b_q - S1;
`ifdef RC5_DEC_SELFCHECK_EN
        state_d = CHK_PRE;
`else
        state_d = DONE;
`endif
      end
`ifdef RC5_DEC_SELFCHECK_EN
      // Re-encryption runs in ea/eb so a/b keep the plaintext for p
      CHK_PRE: begin
        ea_d    = a_q + S0;
        eb_d    = b_q + S1;
        state_d = CHK_A;
      end
      CHK_A: begin
        ea_d    = rotl8(ea_q ^ eb_q, eb_q[2:0]) + S2;
        state_d = CHK_B;
      end
      CHK_B: begin
        eb_d    = rotl8(eb_q ^ ea_q, ea_q[2:0]) + S3;
        state_d = DONE;
      end
`endif
      DONE: begin
        p_d     = {a_q, b_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef RC5_DEC_SELFCHECK_EN
        err_d   = ({ea_q, eb_q} != ct_q);
`endif
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign p        = p_q;
  assign busy     = busy_q;
  assign dec_done = done_q;
`ifdef RC5_DEC_SELFCHECK_EN
  assign dec_err  = err_q;
`else
  assign dec_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rc5_dec_16bit.sv
// Directed and randomized check of rc5_dec_16bit against hand-computed vectors and a forward RC5 model.
// Honors RC5_DEC_SELFCHECK_EN for the expected latency.
module tb_rc5_dec_16bit;

`ifdef RC5_DEC_SELFCHECK_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif
  localparam logic [7:0] K0 = 8'h20, K1 = 8'h10, K2 = 8'hFF, K3 = 8'hFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_start;
  logic [15:0] c;
  logic [15:0] p;
  logic        busy, dec_done, dec_err;

  int n_assert = 0;
  int n_fail   = 0;

  rc5_dec_16bit #(.S0(K0), .S1(K1), .S2(K2), .S3(K3)) dut (
    .clock    (clock),
    .reset    (reset),
    .dec_start(dec_start),
    .c        (c),
    .p        (p),
    .busy     (busy),
    .dec_done (dec_done),
    .dec_err  (dec_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_rotl(input logic [7:0] x, input logic [2:0] n);
    logic [7:0] r;
    r = x;
    for (int unsigned i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [15:0] ref_enc(input logic [15:0] pt);
    logic [7:0] a, b;
    a = pt[15:8] + K0;
    b = pt[7:0] + K1;
    a = ref_rotl(a ^ b, b[2:0]) + K2;
    b = ref_rotl(b ^ a, a[2:0]) + K3;
    return {a, b};
  endfunction

  // Called at a negedge: request one decryption, return cycles from the sampling edge to dec_done (-1 on timeout).
  task automatic do_op(input logic [15:0] cin, output int lat);
    c = cin;
    dec_start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) dec_start = 1'b0;
      if (dec_done === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] pt;

    reset = 1'b1;
    dec_start = 1'b0;
    c = '0;
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_p", {16'h0, p}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, dec_done}, 32'h0);
    chk("rst_err", {31'h0, dec_err}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Ciphertext of plaintext 0000
    do_op(16'h2F9E, lat);
    chk("lat_2f9e", lat, LAT);
    chk("p_2f9e", {16'h0, p}, 32'h0000);
    chk("err_2f9e", {31'h0, dec_err}, 32'h0);
    @(negedge clock);

    // 6687 -> 1234, busy profile and single-cycle pulse
    c = 16'h6687;
    dec_start = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      if (k == 1) dec_start = 1'b0;
      chk("busy_run", {31'h0, busy}, 32'h1);
      chk("done_early", {31'h0, dec_done}, 32'h0);
    end
    @(negedge clock);
    chk("done_6687", {31'h0, dec_done}, 32'h1);
    chk("p_6687", {16'h0, p}, 32'h1234);
    chk("err_6687", {31'h0, dec_err}, 32'h0);
    @(negedge clock);
    chk("done_pulse", {31'h0, dec_done}, 32'h0);
    chk("busy_idle", {31'h0, busy}, 32'h0);
    chk("p_hold", {16'h0, p}, 32'h1234);

    // dec_start held, c changed mid-operation, back-to-back second op
    c = 16'h6687;
    dec_start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) c = 16'hFFFF;
      if (dec_done === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    chk("lat_hold", lat, LAT);
    chk("p_hold_first", {16'h0, p}, 32'h1234);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) begin
        dec_start = 1'b0;
        chk("b2b_accept", {31'h0, busy}, 32'h1);
      end
      if (dec_done === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    chk("lat_b2b", lat, LAT);
    chk("p_ffff", {16'h0, p}, 32'hDFEF);
    @(negedge clock);

    // Reset during RND_A
    c = 16'h6687;
    dec_start = 1'b1;
    @(negedge clock);
    dec_start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_p", {16'h0, p}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, dec_done}, 32'h0);
    chk("abort_err", {31'h0, dec_err}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (dec_done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_p_kept", {16'h0, p}, 32'h0);
    do_op(16'h2F9E, lat);
    chk("lat_after_rst", lat, LAT);
    chk("p_after_rst", {16'h0, p}, 32'h0000);
    @(negedge clock);

    // Random round trips through the forward model
    for (int i = 0; i < 1000; i++) begin
      pt = 16'($urandom);
      do_op(ref_enc(pt), lat);
      chk("rnd_lat", lat, LAT);
      chk("rnd_p", {16'h0, p}, {16'h0, pt});
      chk("rnd_err", {31'h0, dec_err}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
